// File: rtl/jtframe_sdram_arb.sv
// Round-robin arbiter that shares one SDRAM read channel among SLOTS ROM
// requesters. Only one transaction is in flight at a time. New grants are
// held off during ROM download. A refresh window opens when nothing is pending.
//
// Handshakes:
// - slot_req[i] is a level. The slot holds it until slot_ok[i] pulses.
// - sdram_req stays high from the grant until the cycle sdram_ack is seen.
// - data_rdy qualifies data_read for a single cycle. It is accepted in WAIT,
//   or in REQ together with sdram_ack.
// - slot_ok is a one-cycle pulse. slot_data keeps the word until the next completion.
module jtframe_sdram_arb #(
  parameter int SLOTS = 4,
  parameter int AW    = 22,
  parameter int TOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  downloading,
  input  logic [SLOTS-1:0]      slot_req,
  input  logic [SLOTS*AW-1:0]   slot_addr,
  input  logic [SLOTS*2-1:0]    slot_bank,
  output logic [SLOTS-1:0]      slot_ok,
  output logic [31:0]           slot_data,
  output logic                  sdram_req,
  output logic [AW-1:0]         sdram_addr,
  output logic [1:0]            sdram_bank,
  input  logic                  sdram_ack,
  input  logic                  data_rdy,
  input  logic [31:0]           data_read,
  output logic                  refresh_en,
  output logic                  busy,
  output logic                  tout_err
);

  localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [7:0] TOUT_C = 8'(TOUT);
  localparam logic [SLOTS-1:0] ONE_HOT0 = {{(SLOTS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

  state_t           state_q;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    grant_q, grant_d;
  logic [7:0]       cnt_q;
  logic             sdram_req_q;
  logic [AW-1:0]    sdram_addr_q;
  logic [1:0]       sdram_bank_q;
  logic [SLOTS-1:0] slot_ok_q;
  logic [31:0]      slot_data_q;
  logic             refresh_en_q;
  logic             tout_err_q;

  // Pick the first requesting slot at or after ptr_q, with wrap-around.
  // The loop runs downwards so the smallest offset is assigned last and wins.
  always_comb begin
    grant_d = '0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      int s;
      logic [PW-1:0] idx;
      s = int'(ptr_q) + k;
      if (s >= SLOTS) s = s - SLOTS;
      idx = PW'(s);
      if (slot_req[idx]) grant_d = idx;
    end
    if (grant_d == PW'(SLOTS - 1)) ptr_d = '0;
    else                           ptr_d = grant_d + 1'b1;
  end

  // Arbitration FSM. All outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      cnt_q        <= '0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
      sdram_bank_q <= '0;
      slot_ok_q    <= '0;
      slot_data_q  <= '0;
      refresh_en_q <= 1'b0;
      tout_err_q   <= 1'b0;
    end else begin
      slot_ok_q    <= '0;
      refresh_en_q <= (state_q == ST_IDLE) && !(|slot_req) && !downloading;
      case (state_q)
        ST_IDLE: begin
          if (!downloading && (|slot_req)) begin
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            sdram_addr_q <= slot_addr[int'(grant_d)*AW +: AW];
            sdram_bank_q <= slot_bank[int'(grant_d)*2 +: 2];
            sdram_req_q  <= 1'b1;
            state_q      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (sdram_ack) begin
            sdram_req_q <= 1'b0;
            cnt_q       <= '0;
            if (data_rdy) begin
              // The controller answered in the same cycle, so WAIT is skipped.
              slot_data_q <= data_read;
              slot_ok_q   <= ONE_HOT0 << grant_q;
              state_q     <= ST_DONE;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (data_rdy) begin
            slot_data_q <= data_read;
            slot_ok_q   <= ONE_HOT0 << grant_q;
            state_q     <= ST_DONE;
          end else if (cnt_q == TOUT_C) begin
            // Abandon the read. The requesting slot keeps its request and
            // can be granted again later.
            tout_err_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign slot_ok    = slot_ok_q;
  assign slot_data  = slot_data_q;
  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;
  assign sdram_bank = sdram_bank_q;
  assign refresh_en = refresh_en_q;
  assign busy       = (state_q != ST_IDLE);
  assign tout_err   = tout_err_q;

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
// Bench for jtframe_sdram_arb. It runs directed scenarios and then a random
// phase. A transaction-level model of the arbiter is checked every cycle.
module tb_jtframe_sdram_arb;

  localparam int SLOTS = 4;
  localparam int AW    = 22;
  localparam int TOUT  = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                downloading = 1'b0;
  logic [SLOTS-1:0]    slot_req    = '0;
  logic [SLOTS*AW-1:0] slot_addr   = '0;
  logic [SLOTS*2-1:0]  slot_bank   = '0;
  logic [SLOTS-1:0]    slot_ok;
  logic [31:0]         slot_data;
  logic                sdram_req;
  logic [AW-1:0]       sdram_addr;
  logic [1:0]          sdram_bank;
  logic                sdram_ack   = 1'b0;
  logic                data_rdy    = 1'b0;
  logic [31:0]         data_read   = '0;
  logic                refresh_en;
  logic                busy;
  logic                tout_err;

  jtframe_sdram_arb #(.SLOTS(SLOTS), .AW(AW), .TOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .slot_req(slot_req), .slot_addr(slot_addr), .slot_bank(slot_bank),
    .slot_ok(slot_ok), .slot_data(slot_data),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_bank(sdram_bank),
    .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read),
    .refresh_en(refresh_en), .busy(busy), .tout_err(tout_err)
  );

  // ---------------- scoreboard counters ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic chk_en = 1'b0;
  logic [31:0] exp_q[$];   // expected grant order in the round-robin scenario

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_active: a read is outstanding. m_acked: the controller has taken it.
  // m_done: the completion pulse is being shown.
  logic          m_active, m_acked, m_done;
  int            m_ptr, m_grant, m_wait;
  logic          e_req, e_refresh, e_tout;
  logic [AW-1:0] e_addr;
  logic [1:0]    e_bank;
  logic [SLOTS-1:0] e_ok;
  logic [31:0]   e_data;

  function automatic int rr_pick(input logic [SLOTS-1:0] r, input int p);
    for (int k = 0; k < SLOTS; k++)
      if (r[(p + k) % SLOTS]) return (p + k) % SLOTS;
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0; m_acked <= 1'b0; m_done <= 1'b0;
      m_ptr <= 0; m_grant <= 0; m_wait <= 0;
      e_req <= 1'b0; e_refresh <= 1'b0; e_tout <= 1'b0;
      e_addr <= '0; e_bank <= '0; e_ok <= '0; e_data <= '0;
    end else begin
      e_refresh <= !m_active && !m_done && (slot_req == '0) && !downloading;
      e_ok <= '0;
      if (!m_active && !m_done) begin
        if (!downloading && slot_req != '0) begin
          m_grant  <= rr_pick(slot_req, m_ptr);
          m_ptr    <= (rr_pick(slot_req, m_ptr) + 1) % SLOTS;
          e_addr   <= slot_addr[rr_pick(slot_req, m_ptr)*AW +: AW];
          e_bank   <= slot_bank[rr_pick(slot_req, m_ptr)*2 +: 2];
          e_req    <= 1'b1;
          m_active <= 1'b1;
          m_acked  <= 1'b0;
        end
      end else if (m_active && !m_acked) begin
        if (sdram_ack) begin
          e_req <= 1'b0;
          if (data_rdy) begin
            e_data <= data_read; m_active <= 1'b0; m_done <= 1'b1;
            e_ok <= SLOTS'(1) << m_grant;
          end else begin
            m_acked <= 1'b1; m_wait <= 0;
          end
        end
      end else if (m_active) begin
        if (data_rdy) begin
          e_data <= data_read; m_active <= 1'b0; m_acked <= 1'b0; m_done <= 1'b1;
          e_ok <= SLOTS'(1) << m_grant;
        end else if (m_wait == TOUT) begin
          e_tout <= 1'b1; m_active <= 1'b0; m_acked <= 1'b0;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else begin
        m_done <= 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("sdram_req",  32'(sdram_req),  32'(e_req));
      chk("sdram_addr", 32'(sdram_addr), 32'(e_addr));
      chk("sdram_bank", 32'(sdram_bank), 32'(e_bank));
      chk("slot_ok",    32'(slot_ok),    32'(e_ok));
      chk("slot_data",  slot_data,       e_data);
      chk("refresh_en", 32'(refresh_en), 32'(e_refresh));
      chk("busy",       32'(busy),       32'(m_active | m_done));
      chk("tout_err",   32'(tout_err),   32'(e_tout));
      chk("ok_onehot",  32'($countones(slot_ok) <= 1), 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    slot_req = '0; sdram_ack = 1'b0; data_rdy = 1'b0; downloading = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [1:0] b);
    slot_addr[i*AW +: AW] = a;
    slot_bank[i*2 +: 2]   = b;
  endtask

  task automatic wait_req();
    int budget = 20;
    while (!e_req && budget > 0) begin
      tick();
      budget--;
    end
    chk("grant_wait", 32'(e_req), 32'd1);
  endtask

  // Serve one read. The caller has already set the slot requests.
  // ok_seen is the value of slot_ok in the completion cycle.
  task automatic run_txn(input int ack_dly, input int rdy_dly, input bit same,
                         input logic [31:0] d, output logic [SLOTS-1:0] ok_seen);
    wait_req();
    repeat (ack_dly) tick();
    sdram_ack = 1'b1;
    data_rdy  = same;
    data_read = d;
    tick();
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    if (!same) begin
      repeat (rdy_dly) tick();
      data_rdy  = 1'b1;
      data_read = d;
      tick();
      data_rdy = 1'b0;
    end
    ok_seen = slot_ok;
  endtask

  // ---------------- main sequence ----------------
  logic [SLOTS-1:0] ok;

  initial begin
    apply_reset();
    chk_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req",  32'(sdram_req), 32'd0);
    chk("rst_ok",   32'(slot_ok), 32'd0);
    chk("rst_data", slot_data, 32'd0);

    // Slot 2 read. The controller acks after 3 cycles and returns data 4 cycles later.
    set_slot(2, 22'h01234, 2'd1);
    slot_req = 4'b0100;
    wait_req();
    chk("t1_addr", 32'(sdram_addr), 32'h01234);
    chk("t1_bank", 32'(sdram_bank), 32'd1);
    set_slot(2, 22'h3ABCD, 2'd3);           // must not affect the latched address
    run_txn(3, 4, 0, 32'hDEADBEEF, ok);
    chk("t1_ok",   32'(ok), 32'h4);
    chk("t1_data", slot_data, 32'hDEADBEEF);
    slot_req = '0;
    tick();
    chk("t1_ok_pulse", 32'(slot_ok), 32'h0);

    // All slots request continuously. Grants must rotate 0,1,2,3,0.
    apply_reset();
    for (int i = 0; i < SLOTS; i++) set_slot(i, AW'(22'h100 * (i + 1)), 2'(i));
    exp_q = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h1};
    slot_req = 4'hF;
    for (int n = 0; n < 5; n++) begin
      run_txn($urandom_range(0, 2), $urandom_range(0, 3), 0, $urandom, ok);
      chk("t2_order", 32'(ok), exp_q.pop_front());
    end
    slot_req = '0;

    // While downloading, no grant is made and no refresh window opens.
    apply_reset();
    downloading = 1'b1;
    slot_req = 4'b0011;
    repeat (6) begin
      tick();
      chk("t3_no_req", 32'(sdram_req), 32'd0);
      chk("t3_no_ref", 32'(refresh_en), 32'd0);
    end
    downloading = 1'b0;
    tick();
    chk("t3_grant",  32'(sdram_req), 32'd1);
    chk("t3_addr0",  32'(sdram_addr), 32'h100);
    run_txn(0, 1, 0, 32'h12345678, ok);
    chk("t3_ok", 32'(ok), 32'h1);
    slot_req = '0;
    repeat (3) tick();
    chk("t3_refresh", 32'(refresh_en), 32'd1);

    // Ack and data arrive together. WAIT is skipped.
    slot_req = 4'b0010;
    run_txn(1, 0, 1, 32'h00FF00FF, ok);
    chk("t4_ok",   32'(ok), 32'h2);
    chk("t4_data", slot_data, 32'h00FF00FF);
    slot_req = '0;

    // No data after the ack: the read times out and the next request is served.
    tick();
    slot_req = 4'b0010;
    wait_req();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    repeat (255) tick();
    chk("t5_pre_tout", 32'(tout_err), 32'd0);
    chk("t5_pre_busy", 32'(busy), 32'd1);
    tick();
    chk("t5_tout", 32'(tout_err), 32'd1);
    chk("t5_idle", 32'(busy), 32'd0);
    chk("t5_no_ok", 32'(slot_ok), 32'd0);
    slot_req = 4'b1000;
    run_txn(0, 2, 0, 32'hCAFEF00D, ok);
    chk("t5_next_ok", 32'(ok), 32'h8);
    chk("t5_sticky", 32'(tout_err), 32'd1);
    slot_req = '0;

    // Reset asserted during WAIT takes effect immediately.
    tick();
    slot_req = 4'b0100;
    wait_req();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    chk("t6_req",  32'(sdram_req), 32'd0);
    chk("t6_ok",   32'(slot_ok), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_tout", 32'(tout_err), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    slot_req = 4'hF;
    wait_req();
    chk("t6_ptr0", 32'(sdram_addr), 32'h100);
    run_txn(0, 0, 0, 32'h0BADF00D, ok);
    chk("t6_ok", 32'(ok), 32'h1);
    slot_req = '0;

    // Random traffic. The controller reacts to the model's view of sdram_req.
    for (int c = 0; c < 4000; c++) begin
      tick();
      if ($urandom_range(0, 3) == 0) slot_req = SLOTS'($urandom);
      if ($urandom_range(0, 19) == 0) downloading = ~downloading;
      for (int i = 0; i < SLOTS; i++) set_slot(i, AW'($urandom), 2'($urandom));
      sdram_ack = e_req && ($urandom_range(0, 2) == 0);
      data_rdy  = ($urandom_range(0, 3) == 0);
      data_read = $urandom;
    end
    tick();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Guard against a run that never reaches the end of the sequence.
  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
